// File: rtl/fp_mul_pipe.sv
// Pipelined floating-point multiplier with configurable exponent/fraction widths.
// Three register stages (unpack/classify, multiply, normalise/round/pack) under
// one global stall: every stage advances together whenever the output register
// is empty or being drained. Truncate or round-to-nearest-even is chosen per
// operand pair and travels down the pipe with it. Results never include
// denormals: tiny results flush to signed zero, huge ones saturate to infinity.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23,
  localparam int W = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y,
  output logic         out_overflow,
  output logic         out_underflow,
  output logic         out_invalid
);

  localparam int MW  = FRAC_W + 1;          // mantissa incl. hidden bit
  localparam int PW  = 2 * MW;              // full product width
  localparam int EW2 = EXP_W + 2;           // signed working exponent width
  localparam int LZW = $clog2(PW) + 1;

  localparam logic signed [EW2-1:0] BIAS    = EW2'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EXP_MAX = EW2'((2 ** EXP_W) - 1);
  localparam logic signed [EW2-1:0] EXP_ONE = EW2'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W - 1){1'b0}}};

  // Special-case outcome decided once in stage 1, in priority order.
  typedef enum logic [1:0] {EXC_NONE, EXC_NAN, EXC_INF, EXC_ZERO} exc_t;

  logic adv;
  logic out_valid_reg;

  assign adv      = !out_valid_reg || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------- unpack
  logic [W-1:0]     op_word [2];
  logic [1:0]       op_sign, op_zero, op_inf, op_nan;
  logic [EXP_W-1:0] op_exp [2];
  logic [MW-1:0]    op_man [2];

  assign op_word[0] = in_a;
  assign op_word[1] = in_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      logic [EXP_W-1:0]  exp_field;
      logic [FRAC_W-1:0] frac_field;
      assign exp_field   = op_word[gi][W-2 -: EXP_W];
      assign frac_field  = op_word[gi][FRAC_W-1:0];
      assign op_sign[gi] = op_word[gi][W-1];
      assign op_zero[gi] = (exp_field == '0) && (frac_field == '0);
      assign op_inf[gi]  = (exp_field == '1) && (frac_field == '0);
      assign op_nan[gi]  = (exp_field == '1) && (frac_field != '0);
      // Denormals behave as exponent 1 with a clear hidden bit.
      assign op_exp[gi]  = (exp_field == '0) ? EXP_W'(1) : exp_field;
      assign op_man[gi]  = {exp_field != '0, frac_field};
    end
  endgenerate

  exc_t exc_next;

  // Classify the operand pair into the highest-priority special case.
  always_comb begin
    exc_next = EXC_NONE;
    if ((|op_nan) || (op_inf[0] && op_zero[1]) || (op_inf[1] && op_zero[0]))
      exc_next = EXC_NAN;
    else if (|op_inf)
      exc_next = EXC_INF;
    else if (|op_zero)
      exc_next = EXC_ZERO;
  end

  logic             s1_valid_reg, s1_sign_reg, s1_rnd_reg;
  exc_t             s1_exc_reg;
  logic [EXP_W-1:0] s1_exp_a_reg, s1_exp_b_reg;
  logic [MW-1:0]    s1_man_a_reg, s1_man_b_reg;

  // Stage 1 register: classified operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s1_rnd_reg   <= 1'b0;
      s1_exc_reg   <= EXC_NONE;
      s1_exp_a_reg <= '0;
      s1_exp_b_reg <= '0;
      s1_man_a_reg <= '0;
      s1_man_b_reg <= '0;
    end else if (adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_sign_reg  <= op_sign[0] ^ op_sign[1];
        s1_rnd_reg   <= rnd_mode;
        s1_exc_reg   <= exc_next;
        s1_exp_a_reg <= op_exp[0];
        s1_exp_b_reg <= op_exp[1];
        s1_man_a_reg <= op_man[0];
        s1_man_b_reg <= op_man[1];
      end
    end
  end

  // -------------------------------------------------------------- multiply
  logic [PW-1:0]           prod_next;
  logic signed [EW2-1:0]   exp_sum_next;

  assign prod_next    = PW'(s1_man_a_reg) * PW'(s1_man_b_reg);
  assign exp_sum_next = $signed(EW2'(s1_exp_a_reg)) + $signed(EW2'(s1_exp_b_reg)) - BIAS;

  logic                  s2_valid_reg, s2_sign_reg, s2_rnd_reg;
  exc_t                  s2_exc_reg;
  logic signed [EW2-1:0] s2_exp_reg;
  logic [PW-1:0]         s2_prod_reg;

  // Stage 2 register: raw product and biased exponent sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_sign_reg  <= 1'b0;
      s2_rnd_reg   <= 1'b0;
      s2_exc_reg   <= EXC_NONE;
      s2_exp_reg   <= '0;
      s2_prod_reg  <= '0;
    end else if (adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_sign_reg <= s1_sign_reg;
        s2_rnd_reg  <= s1_rnd_reg;
        s2_exc_reg  <= s1_exc_reg;
        s2_exp_reg  <= exp_sum_next;
        s2_prod_reg <= prod_next;
      end
    end
  end

  // ------------------------------------------------- normalise/round/pack
  logic [LZW-1:0] lzc;

  // Leading-zero count of the product; the highest set bit wins.
  always_comb begin
    lzc = '0;
    for (int i = 0; i < PW; i++)
      if (s2_prod_reg[i]) lzc = LZW'(PW - 1 - i);
  end

  logic [PW-1:0]         norm_prod;
  logic signed [EW2-1:0] exp_norm, exp_round;
  logic [FRAC_W-1:0]     frac_trunc;
  logic [FRAC_W:0]       frac_sum;
  logic                  guard_bit, sticky_bit, round_inc;
  logic [W-1:0]          y_next;
  logic                  ovf_next, unf_next, inv_next;

  // Normalise, round, then resolve exceptions into the packed result.
  always_comb begin
    // The product has two integer bits, so an MSB hit means exponent+1 and
    // each further leading zero costs one more.
    norm_prod  = s2_prod_reg << lzc;
    exp_norm   = s2_exp_reg + EXP_ONE - $signed(EW2'(lzc));
    frac_trunc = norm_prod[PW-2 -: FRAC_W];
    guard_bit  = norm_prod[PW-MW-1];
    sticky_bit = |norm_prod[PW-MW-2:0];
    round_inc  = s2_rnd_reg && guard_bit && (sticky_bit || frac_trunc[0]);
    frac_sum   = {1'b0, frac_trunc} + (FRAC_W + 1)'(round_inc);
    // A carry out leaves the fraction bits at zero and bumps the exponent.
    exp_round  = frac_sum[FRAC_W] ? (exp_norm + EXP_ONE) : exp_norm;

    y_next   = '0;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    inv_next = 1'b0;
    case (s2_exc_reg)
      EXC_NAN: begin
        y_next   = QNAN;
        inv_next = 1'b1;
      end
      EXC_INF:  y_next = {s2_sign_reg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      EXC_ZERO: y_next = {s2_sign_reg, {(W - 1){1'b0}}};
      default: begin
        if (exp_round >= EXP_MAX) begin
          y_next   = {s2_sign_reg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_next = 1'b1;
        end else if ((exp_round < EXP_ONE) || !norm_prod[PW-1]) begin
          // A clear hidden bit cannot occur for nonzero operands; flush anyway.
          y_next   = {s2_sign_reg, {(W - 1){1'b0}}};
          unf_next = 1'b1;
        end else begin
          y_next = {s2_sign_reg, exp_round[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
        end
      end
    endcase
  end

  logic [W-1:0] out_y_reg;
  logic         out_overflow_reg, out_underflow_reg, out_invalid_reg;

  // Output register: loads on advance, holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg     <= 1'b0;
      out_y_reg         <= '0;
      out_overflow_reg  <= 1'b0;
      out_underflow_reg <= 1'b0;
      out_invalid_reg   <= 1'b0;
    end else if (adv) begin
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        out_y_reg         <= y_next;
        out_overflow_reg  <= ovf_next;
        out_underflow_reg <= unf_next;
        out_invalid_reg   <= inv_next;
      end
    end
  end

  assign out_valid     = out_valid_reg;
  assign out_y         = out_y_reg;
  assign out_overflow  = out_overflow_reg;
  assign out_underflow = out_underflow_reg;
  assign out_invalid   = out_invalid_reg;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe (FP32 configuration): directed corner cases, a
// backpressure scenario, a mid-flight reset and randomized traffic, all
// scored against an arithmetic reference model and an in-order queue.
module tb_fp_mul_pipe;

  logic        clk, rst_n, in_valid, in_ready, rnd_mode;
  logic        out_valid, out_ready, out_overflow, out_underflow, out_invalid;
  logic [31:0] in_a, in_b, out_y;

  fp_mul_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_overflow(out_overflow), .out_underflow(out_underflow),
    .out_invalid(out_invalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before 500000");
    $fatal(1, "watchdog expired");
  end

  int  n_compared = 0;
  int  n_mismatched = 0;
  int  cyc = 0;
  int  n_txn = 0;
  bit  check_lat = 1'b0;
  logic [34:0] exp_q[$];      // {ovf, unf, inv, y}
  int          acc_cyc_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Reference: exact integer product, renormalised and rounded with plain arithmetic.
  function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit rnd);
    int ea, eb, xa, xb, k, shift, e;
    longint fa, fb, ma, mb, p, m, rem, half;
    bit s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    s  = a[31] ^ b[31];
    nan_a  = (ea == 255) && (fa != 0);
    nan_b  = (eb == 255) && (fb != 0);
    inf_a  = (ea == 255) && (fa == 0);
    inf_b  = (eb == 255) && (fb == 0);
    zero_a = (ea == 0) && (fa == 0);
    zero_b = (eb == 0) && (fb == 0);
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
      return {3'b001, 32'h7FC00000};
    if (inf_a || inf_b) return {3'b000, s, 8'hFF, 23'd0};
    if (zero_a || zero_b) return {3'b000, s, 31'd0};
    ma = (ea == 0) ? fa : fa + 8388608;
    mb = (eb == 0) ? fb : fb + 8388608;
    xa = (ea == 0) ? 1 : ea;
    xb = (eb == 0) ? 1 : eb;
    p  = ma * mb;                     // value = p * 2^(xa+xb-254-46)
    k  = 47;
    while (k > 0 && ((p >> k) & 1) == 0) k--;
    e     = xa + xb - 127 + (k - 46);
    shift = k - 23;
    if (shift > 0) begin
      m    = p >> shift;
      rem  = p - (m << shift);
      half = longint'(1) << (shift - 1);
      if (rnd && (rem > half || (rem == half && (m % 2) == 1))) m = m + 1;
    end else begin
      m = p << (-shift);
    end
    if (m == 16777216) begin
      m = 8388608;
      e = e + 1;
    end
    if (e >= 255) return {3'b100, s, 8'hFF, 23'd0};
    if (e < 1) return {3'b010, s, 31'd0};
    return {3'b000, s, 8'(e), 23'(m)};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 9))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'h01;
      3:       e = 8'hFE;
      4, 5, 6: e = 8'($urandom_range(100, 154));
      default: e = 8'($urandom);
    endcase
    f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  // One clock cycle: drive at negedge, sample 1 time unit later, score handshakes.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b, input bit r,
                      input bit ordy, input logic [34:0] expv, output bit accepted);
    logic [34:0] want;
    int          c;
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    rnd_mode  = r;
    out_ready = ordy;
    #1;
    cyc++;
    accepted = v && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", {63'd0, out_valid}, 64'd0);
      end else begin
        want = exp_q.pop_front();
        c    = acc_cyc_q.pop_front();
        n_txn++;
        $display("txn %0d: y=%h ovf=%0b unf=%0b inv=%0b (want y=%h flags=%b)",
                 n_txn, out_y, out_overflow, out_underflow, out_invalid, want[31:0], want[34:32]);
        check_eq("result", {out_overflow, out_underflow, out_invalid, out_y}, want);
        if (check_lat) check_eq("latency", cyc - c, 3);
      end
    end
    if (accepted) begin
      exp_q.push_back(expv);
      acc_cyc_q.push_back(cyc);
    end
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 35'd0, acc);
    if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input bit r, input logic [34:0] expv);
    bit acc;
    step(1'b1, a, b, r, 1'b1, expv, acc);
    check_eq("issue_accept", {63'd0, acc}, 64'd1);
    drain();
  endtask

  logic [31:0] op_a [4];
  logic [31:0] op_b [4];
  bit          op_r [4];

  initial begin
    bit          acc, have;
    int          idx;
    logic [31:0] ra, rb;
    bit          rr;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; rnd_mode = 1'b0; out_ready = 1'b0;
    #3;
    check_eq("reset_out", {out_valid, out_overflow, out_underflow, out_invalid, out_y}, 64'd0);
    check_eq("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases, pipeline otherwise empty, latency checked.
    check_lat = 1'b1;
    run_one(32'h40000000, 32'h40400000, 1'b0, {3'b000, 32'h40C00000});
    run_one(32'h3F800005, 32'h3FC00000, 1'b0, {3'b000, 32'h3FC00007});
    run_one(32'h3F800005, 32'h3FC00000, 1'b1, {3'b000, 32'h3FC00008});
    run_one(32'h3F800001, 32'h3FC00000, 1'b1, {3'b000, 32'h3FC00002});
    run_one(32'h7F000000, 32'h7F000000, 1'b0, {3'b100, 32'h7F800000});
    run_one(32'h80800000, 32'h00800000, 1'b0, {3'b010, 32'h80000000});
    run_one(32'h00400000, 32'h4B000000, 1'b0, ref_mul(32'h00400000, 32'h4B000000, 1'b0));
    run_one(32'h7F800000, 32'h00000000, 1'b0, {3'b001, 32'h7FC00000});
    run_one(32'hFF800000, 32'h40000000, 1'b0, {3'b000, 32'hFF800000});
    run_one(32'h7FC00001, 32'h3F800000, 1'b1, {3'b001, 32'h7FC00000});
    run_one(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1, ref_mul(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1));
    check_lat = 1'b0;

    // Backpressure: four back-to-back ops while the consumer stalls.
    for (int i = 0; i < 4; i++) begin
      op_a[i] = rand_op();
      op_b[i] = rand_op();
      op_r[i] = 1'($urandom);
    end
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      if (idx < 4) step(1'b1, op_a[idx], op_b[idx], op_r[idx], 1'b0, ref_mul(op_a[idx], op_b[idx], op_r[idx]), acc);
      else         step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 35'd0, acc);
      if (acc) idx++;
      if (i >= 3) begin
        check_eq("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check_eq("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        check_eq("bp_hold_y", {32'd0, out_y}, {32'd0, exp_q[0][31:0]});
      end
    end
    check_eq("bp_accepted", idx, 3);
    for (int i = 0; i < 12 && (idx < 4 || exp_q.size() > 0); i++) begin
      if (idx < 4) step(1'b1, op_a[idx], op_b[idx], op_r[idx], 1'b1, ref_mul(op_a[idx], op_b[idx], op_r[idx]), acc);
      else         step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 35'd0, acc);
      if (acc) idx++;
      if (i < 4) check_eq("bp_stream_valid", {63'd0, out_valid}, 64'd1);
    end
    check_eq("bp_all_done", exp_q.size() + (4 - idx), 0);

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      ra = rand_op();
      rb = rand_op();
      step(1'b1, ra, rb, 1'b0, 1'b0, ref_mul(ra, rb, 1'b0), acc);
    end
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 35'd0, acc);
    check_eq("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async", {out_valid, out_overflow, out_underflow, out_invalid, out_y}, 64'd0);
    exp_q.delete();
    acc_cyc_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 35'd0, acc);
      check_eq("no_stale", {63'd0, out_valid}, 64'd0);
    end
    check_lat = 1'b1;
    run_one(32'hC0000000, 32'h40400000, 1'b0, {3'b000, 32'hC0C00000});
    check_lat = 1'b0;

    // Randomized traffic with random stalls; operands held until accepted.
    have = 1'b0;
    ra = '0; rb = '0; rr = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!have && $urandom_range(0, 9) < 7) begin
        ra = rand_op();
        rb = rand_op();
        rr = 1'($urandom);
        have = 1'b1;
      end
      step(have, ra, rb, rr, $urandom_range(0, 3) != 0, ref_mul(ra, rb, rr), acc);
      if (acc) have = 1'b0;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
